// File: rtl/score_seven_seg.sv
// Score display block: converts a 12-bit binary score to packed BCD with a
// sequential double-dabble engine and multiplexes it onto a 7-segment display.
module score_seven_seg #(
    parameter int unsigned REFRESH_CYCLES = 65000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [11:0] score_in,
    output logic [15:0] bcd_out,
    output logic        busy_out,
    output logic [7:0]  an_out,
    output logic [6:0]  seg_out
);

    localparam int unsigned CNT_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [11:0]      last_score_q, last_score_d;
    logic [27:0]      shift_q, shift_d;
    logic [3:0]       iter_q, iter_d;
    logic [15:0]      bcd_q, bcd_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] refresh_q, refresh_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       digit_s;
    logic [3:0]       blank_s;

    // One double-dabble step: correct every BCD nibble >= 5, then shift left.
    function automatic logic [27:0] dabble_step(input logic [27:0] s);
        logic [27:0] t;
        logic [3:0]  nib;
        t = s;
        for (int i = 0; i < 4; i++) begin
            nib = t[12 + 4*i +: 4];
            if (nib >= 4'd5) begin
                t[12 + 4*i +: 4] = nib + 4'd3;
            end else begin
                t[12 + 4*i +: 4] = nib;
            end
        end
        return {t[26:0], 1'b0};
    endfunction

    // Active-low cathode pattern {g,f,e,d,c,b,a}; non-decimal nibbles go dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Converter next state: bcd only changes once, in DONE, so no partial value leaks out.
    always_comb begin
        state_d      = state_q;
        last_score_d = last_score_q;
        shift_d      = shift_q;
        iter_d       = iter_q;
        bcd_d        = bcd_q;
        case (state_q)
            IDLE: begin
                if (score_in != last_score_q) begin
                    shift_d      = {16'h0000, score_in};
                    last_score_d = score_in;
                    iter_d       = 4'd0;
                    state_d      = CONVERT;
                end else begin
                    state_d = IDLE;
                end
            end
            CONVERT: begin
                shift_d = dabble_step(shift_q);
                if (iter_q == 4'd11) begin
                    state_d = DONE;
                end else begin
                    iter_d = iter_q + 4'd1;
                end
            end
            DONE: begin
                bcd_d   = shift_q[27:12];
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == CONVERT) || (state_d == DONE);
    end

    // Digit selection and leading-zero blanking for the display path.
    always_comb begin
        digit_s = 4'd0;
        case (digit_sel_q)
            2'd0:    digit_s = bcd_q[3:0];
            2'd1:    digit_s = bcd_q[7:4];
            2'd2:    digit_s = bcd_q[11:8];
            2'd3:    digit_s = bcd_q[15:12];
            default: digit_s = 4'd0;
        endcase
        blank_s[3] = (bcd_q[15:12] == 4'd0);
        blank_s[2] = blank_s[3] && (bcd_q[11:8] == 4'd0);
        blank_s[1] = blank_s[2] && (bcd_q[7:4] == 4'd0);
        blank_s[0] = 1'b0;
    end

    // Refresh timer, digit scan and registered anode/cathode drive.
    always_comb begin
        refresh_d   = refresh_q;
        digit_sel_d = digit_sel_q;
        if (refresh_q == REFRESH_LAST) begin
            refresh_d   = '0;
            digit_sel_d = digit_sel_q + 2'd1;
        end else begin
            refresh_d = refresh_q + CNT_W'(1);
        end
        if (blank_s[digit_sel_q]) begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
        end else begin
            an_d  = {4'hF, ~(4'b0001 << digit_sel_q)};
            seg_d = seg_encode(digit_s);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            last_score_q <= 12'd0;
            shift_q      <= 28'd0;
            iter_q       <= 4'd0;
            bcd_q        <= 16'h0000;
            busy_q       <= 1'b0;
            refresh_q    <= '0;
            digit_sel_q  <= 2'd0;
            an_q         <= 8'hFF;
            seg_q        <= 7'h7F;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            shift_q      <= shift_d;
            iter_q       <= iter_d;
            bcd_q        <= bcd_d;
            busy_q       <= busy_d;
            refresh_q    <= refresh_d;
            digit_sel_q  <= digit_sel_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign bcd_out  = bcd_q;
    assign busy_out = busy_q;
    assign an_out   = an_q;
    assign seg_out  = seg_q;

endmodule

// File: tb/tb_score_seven_seg.sv
// Directed bench for score_seven_seg: conversion timing, display scan,
// blanking, asynchronous reset and an exhaustive BCD scoreboard.
module tb_score_seven_seg;

    logic        clk_in;
    logic        rst_in;
    logic [11:0] score_in;
    logic [15:0] bcd_out;
    logic        busy_out;
    logic [7:0]  an_out;
    logic [6:0]  seg_out;

    int n_cmp;
    int n_bad;

    logic [7:0] exp_an_1234  [4] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7};
    logic [6:0] exp_seg_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [7:0] exp_an_7     [4] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF};
    logic [6:0] exp_seg_7    [4] = '{7'h78, 7'h7F, 7'h7F, 7'h7F};

    score_seven_seg #(.REFRESH_CYCLES(4)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .score_in (score_in),
        .bcd_out  (bcd_out),
        .busy_out (busy_out),
        .an_out   (an_out),
        .seg_out  (seg_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(v / 1000);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    // Advance until the first cycle of slot 0 (an_out becomes FE), bounded.
    task automatic wait_slot0(input string tag);
        logic [7:0] prev;
        bit         found;
        prev  = an_out;
        found = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            tick();
            if (an_out == 8'hFE && prev != 8'hFE) begin
                found = 1'b1;
            end else begin
                prev = an_out;
            end
        end
        check_eq(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst_in   = 1'b1;
        score_in = 12'd0;

        // Reset values, applied without a clock edge.
        #2 rst_in = 1'b0;
        #1;
        check_eq("rst_bcd",  {16'd0, bcd_out}, 32'h0000);
        check_eq("rst_busy", {31'd0, busy_out}, 32'd0);
        check_eq("rst_an",   {24'd0, an_out}, 32'hFF);
        check_eq("rst_seg",  {25'd0, seg_out}, 32'h7F);
        repeat (2) tick();
        check_eq("rst_hold_an", {24'd0, an_out}, 32'hFF);

        // Release with score 0: no conversion, digit 0 shows "0".
        rst_in = 1'b1;
        tick();
        check_eq("zero_an",  {24'd0, an_out}, 32'hFE);
        check_eq("zero_seg", {25'd0, seg_out}, 32'h40);
        check_eq("zero_busy", {31'd0, busy_out}, 32'd0);
        repeat (3) tick();
        check_eq("zero_busy_later", {31'd0, busy_out}, 32'd0);
        check_eq("zero_bcd", {16'd0, bcd_out}, 32'h0000);

        // Release with 4095: busy through edges 1..13, result on edge 14.
        rst_in   = 1'b0;
        score_in = 12'd4095;
        tick();
        rst_in = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            check_eq($sformatf("max_busy_e%0d", e), {31'd0, busy_out}, 32'd1);
            check_eq($sformatf("max_bcd_e%0d", e), {16'd0, bcd_out}, 32'h0000);
        end
        tick();
        check_eq("max_bcd",  {16'd0, bcd_out}, 32'h4095);
        check_eq("max_busy", {31'd0, busy_out}, 32'd0);

        // 100, then 250 arriving mid-conversion: 100 first, then 250.
        score_in = 12'd100;
        repeat (5) tick();
        score_in = 12'd250;
        repeat (8) tick();
        check_eq("chg_bcd_e13",  {16'd0, bcd_out}, 32'h4095);
        check_eq("chg_busy_e13", {31'd0, busy_out}, 32'd1);
        tick();
        check_eq("chg_bcd_100",  {16'd0, bcd_out}, 32'h0100);
        check_eq("chg_busy_idle", {31'd0, busy_out}, 32'd0);
        tick();
        check_eq("chg_restart_busy", {31'd0, busy_out}, 32'd1);
        repeat (12) tick();
        check_eq("chg_bcd_hold", {16'd0, bcd_out}, 32'h0100);
        tick();
        check_eq("chg_bcd_250", {16'd0, bcd_out}, 32'h0250);

        // Display scan of 1234.
        score_in = 12'd1234;
        repeat (14) tick();
        check_eq("d1234_bcd", {16'd0, bcd_out}, 32'h1234);
        wait_slot0("d1234_sync");
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("d1234_an_s%0d", s),  {24'd0, an_out},  {24'd0, exp_an_1234[s]});
                check_eq($sformatf("d1234_seg_s%0d", s), {25'd0, seg_out}, {25'd0, exp_seg_1234[s]});
                tick();
            end
        end

        // Leading-zero blanking with score 7.
        score_in = 12'd7;
        repeat (14) tick();
        check_eq("d7_bcd", {16'd0, bcd_out}, 32'h0007);
        wait_slot0("d7_sync");
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                check_eq($sformatf("d7_an_s%0d", s),  {24'd0, an_out},  {24'd0, exp_an_7[s]});
                check_eq($sformatf("d7_seg_s%0d", s), {25'd0, seg_out}, {25'd0, exp_seg_7[s]});
                tick();
            end
        end

        // Asynchronous reset between edges during the 6th CONVERT cycle.
        score_in = 12'd3000;
        tick();
        repeat (5) tick();
        check_eq("ar_busy_before", {31'd0, busy_out}, 32'd1);
        #2 rst_in = 1'b0;
        #1;
        check_eq("ar_bcd",  {16'd0, bcd_out}, 32'h0000);
        check_eq("ar_busy", {31'd0, busy_out}, 32'd0);
        check_eq("ar_an",   {24'd0, an_out}, 32'hFF);
        check_eq("ar_seg",  {25'd0, seg_out}, 32'h7F);
        repeat (3) tick();
        check_eq("ar_bcd_hold", {16'd0, bcd_out}, 32'h0000);
        rst_in = 1'b1;
        repeat (13) tick();
        check_eq("ar_bcd_e13", {16'd0, bcd_out}, 32'h0000);
        tick();
        check_eq("ar_reconv", {16'd0, bcd_out}, 32'h3000);

        // Exhaustive scoreboard against a decimal reference.
        for (int v = 0; v < 4096; v++) begin
            score_in = 12'(v);
            repeat (14) tick();
            check_eq($sformatf("sb_%0d", v), {16'd0, bcd_out}, {16'd0, ref_bcd(v)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
